// File: rtl/contador_objetos_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : contador_objetos_pkg
//  Purpose  : Shared constants and types for the IR object counter: FSM state
//             encoding, count limit, BCD digit geometry and a cycle helper.
//  Revision : 1.0 - initial release
// ============================================================================
package contador_objetos_pkg;

    // Largest value the object counter can display
    localparam int MAX_COUNT   = 999;
    localparam int COUNT_W     = 10;
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 3;
    localparam int BCD_W       = BCD_DIGITS * BCD_DIGIT_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUAL_IN  = 3'd1,
        ST_PRESENT  = 3'd2,
        ST_QUAL_OUT = 3'd3,
        ST_GAP      = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    // Converts a millisecond interval to clock cycles, never less than one
    function automatic int cycles_at_least_one(input int freq_hz, input int ms);
        int c;
        c = freq_hz / 1000 * ms;
        return (c < 1) ? 1 : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : contador_bcd
//  Purpose  : Saturating object counter kept simultaneously in binary and in
//             three BCD digits, so the decimal view never lags the binary one.
//  Revision : 1.0 - initial release
// ============================================================================
module contador_bcd
    import contador_objetos_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_i,
    input  logic               clr_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [BCD_W-1:0]   bcd_o,
    output logic               overflow_o
);

    localparam logic [COUNT_W-1:0]     MAX_Q     = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0]     COUNT_ONE = COUNT_W'(1);
    localparam logic [BCD_DIGIT_W-1:0] DIGIT_NINE = BCD_DIGIT_W'(9);
    localparam logic [BCD_DIGIT_W-1:0] DIGIT_ONE  = BCD_DIGIT_W'(1);

    logic [COUNT_W-1:0]                       count_q, count_d;
    logic [BCD_DIGITS-1:0][BCD_DIGIT_W-1:0]   bcd_q, bcd_d;
    logic                                     ovf_q, ovf_d;
    logic                                     carry;

    // Next value: clear wins over increment; increment at the limit only flags overflow
    always_comb begin
        count_d = count_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        carry   = 1'b0;
        if (clr_i) begin
            count_d = '0;
            bcd_d   = '0;
            ovf_d   = 1'b0;
        end else if (inc_i) begin
            if (count_q == MAX_Q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + COUNT_ONE;
                carry   = 1'b1;
                for (int i = 0; i < BCD_DIGITS; i++) begin
                    if (carry) begin
                        if (bcd_q[i] == DIGIT_NINE) begin
                            bcd_d[i] = '0;
                        end else begin
                            bcd_d[i] = bcd_q[i] + DIGIT_ONE;
                            carry    = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Binary, BCD and overflow registers update together on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/contador_objetos.sv
`default_nettype none
// ============================================================================
//  Module   : contador_objetos
//  Purpose  : Counts objects passing an infrared barrier. Debounces entry and
//             exit, enforces a dead time after each exit, and flags a fault
//             when the beam stays blocked too long.
//  Revision : 1.0 - initial release
// ============================================================================
module contador_objetos
    import contador_objetos_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int GAP_MS        = 50,
    parameter int STUCK_MS      = 2000,
    parameter int IR_ACTIVE_LOW = 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ir_i,
    input  logic               en_i,
    input  logic               clr_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [BCD_W-1:0]   bcd_o,
    output logic               event_o,
    output logic               presence_o,
    output logic               fault_o,
    output logic               overflow_o
);

    localparam int DEB_CYC   = cycles_at_least_one(CLOCK_FREQ, DEBOUNCE_MS);
    localparam int GAP_CYC   = cycles_at_least_one(CLOCK_FREQ, GAP_MS);
    localparam int STUCK_CYC = cycles_at_least_one(CLOCK_FREQ, STUCK_MS);

    // One qualification timer serves debounce, gap and fault recovery
    localparam int QT_MAX = (DEB_CYC > GAP_CYC) ? DEB_CYC : GAP_CYC;
    localparam int QT_W   = $clog2(QT_MAX + 1);
    localparam int SK_W   = $clog2(STUCK_CYC + 1);

    localparam logic [QT_W-1:0] QT_ONE     = QT_W'(1);
    localparam logic [QT_W-1:0] DEB_LAST   = QT_W'(DEB_CYC - 1);
    localparam logic [QT_W-1:0] GAP_LAST   = QT_W'(GAP_CYC - 1);
    localparam logic [SK_W-1:0] SK_ONE     = SK_W'(1);
    localparam logic [SK_W-1:0] STUCK_LAST = SK_W'(STUCK_CYC - 1);

    // Sensor level seen while the beam is clear
    localparam logic INACTIVE = (IR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [1:0]      sync_q;
    logic            obj_s;
    state_e          state_q;
    logic [QT_W-1:0] qtim_q;
    logic [SK_W-1:0] stuck_q;
    logic            event_q;
    logic            presence_q;
    logic            fault_q;
    logic            entry;

    // Two-flop synchroniser for the asynchronous sensor line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{INACTIVE}};
        end else begin
            sync_q <= {sync_q[0], ir_i};
        end
    end

    assign obj_s = sync_q[1] ^ INACTIVE;

    // Entry qualifies on the last debounce cycle; shared by FSM and counter
    assign entry = (state_q == ST_QUAL_IN) && obj_s && (qtim_q == DEB_LAST);

    // Object FSM with its timers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            qtim_q     <= '0;
            stuck_q    <= '0;
            event_q    <= 1'b0;
            presence_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            event_q <= entry;
            case (state_q)
                ST_IDLE: begin
                    if (obj_s) begin
                        state_q <= ST_QUAL_IN;
                        qtim_q  <= '0;
                    end
                end
                ST_QUAL_IN: begin
                    if (!obj_s) begin
                        state_q <= ST_IDLE;
                        qtim_q  <= '0;
                    end else if (entry) begin
                        state_q    <= ST_PRESENT;
                        qtim_q     <= '0;
                        stuck_q    <= '0;
                        presence_q <= 1'b1;
                    end else begin
                        qtim_q <= qtim_q + QT_ONE;
                    end
                end
                ST_PRESENT: begin
                    if (stuck_q == STUCK_LAST) begin
                        state_q    <= ST_FAULT;
                        qtim_q     <= '0;
                        presence_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end else begin
                        stuck_q <= stuck_q + SK_ONE;
                        if (!obj_s) begin
                            state_q <= ST_QUAL_OUT;
                            qtim_q  <= '0;
                        end
                    end
                end
                ST_QUAL_OUT: begin
                    // Stuck time keeps running across a brief exit attempt
                    if (stuck_q == STUCK_LAST) begin
                        state_q    <= ST_FAULT;
                        qtim_q     <= '0;
                        presence_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end else begin
                        stuck_q <= stuck_q + SK_ONE;
                        if (obj_s) begin
                            state_q <= ST_PRESENT;
                            qtim_q  <= '0;
                        end else if (qtim_q == DEB_LAST) begin
                            state_q    <= ST_GAP;
                            qtim_q     <= '0;
                            presence_q <= 1'b0;
                        end else begin
                            qtim_q <= qtim_q + QT_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (qtim_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        qtim_q  <= '0;
                    end else begin
                        qtim_q <= qtim_q + QT_ONE;
                    end
                end
                ST_FAULT: begin
                    if (obj_s) begin
                        qtim_q <= '0;
                    end else if (qtim_q == DEB_LAST) begin
                        state_q <= ST_IDLE;
                        qtim_q  <= '0;
                        fault_q <= 1'b0;
                    end else begin
                        qtim_q <= qtim_q + QT_ONE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    qtim_q     <= '0;
                    stuck_q    <= '0;
                    presence_q <= 1'b0;
                    fault_q    <= 1'b0;
                end
            endcase
        end
    end

    contador_bcd u_contador_bcd (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (entry & en_i),
        .clr_i      (clr_i),
        .count_o    (count_o),
        .bcd_o      (bcd_o),
        .overflow_o (overflow_o)
    );

    assign event_o    = event_q;
    assign presence_o = presence_q;
    assign fault_o    = fault_q;

endmodule
`default_nettype wire
